// File: rtl/wshb_fb_responder.sv
// Wishbone classic slave modelling the framebuffer: word storage with byte lanes,
// programmable ack latency, error on out-of-range index, frame pulse and transfer counters.
module wshb_fb_responder #(
  parameter int HDISP   = 800,
  parameter int VDISP   = 480,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic [2:0]  cti_i,
  input  logic [1:0]  bte_i,
  output logic        ack_o,
  output logic        err_o,
  output logic        frame_done,
  output logic [31:0] wr_count,
  output logic [31:0] rd_count
);
  localparam int          DEPTH   = HDISP * VDISP;
  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [29:0] LAST_W  = 30'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic [29:0] r_idx;
  logic        r_we;
  logic [31:0] r_dat;
  logic [3:0]  r_sel;
  logic        r_inrange;
  logic [31:0] r_rdat;
  logic [31:0] r_mem [DEPTH];

  logic        w_req;
  logic        w_adr_inrange;
  logic [29:0] w_idx;
  logic        w_rd_ok;
  logic        w_unused;

  // Burst tags and byte offset carry no meaning here: every access is a classic word access.
  assign w_unused      = &{1'b0, cti_i, bte_i, adr_i[1:0]};
  assign w_req         = cyc_i & stb_i;
  assign w_adr_inrange = {2'b00, adr_i[31:2]} < DEPTH_W;
  // With LATENCY=1 the read happens on the acceptance edge, before the latches hold the request.
  assign w_idx         = (r_state == IDLE) ? adr_i[31:2] : r_idx;
  assign w_rd_ok       = (r_state == IDLE) ? w_adr_inrange : r_inrange;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      IDLE: if (w_req) begin
        w_cnt_next = 4'(LATENCY - 1);
        w_next     = (LATENCY == 1) ? RESP : WAIT;
      end
      WAIT: begin
        if (!w_req) begin
          w_next = IDLE;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
          if (r_cnt == 4'd1) w_next = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign ack_o      = (r_state == RESP) &  r_inrange;
  assign err_o      = (r_state == RESP) & ~r_inrange;
  assign dat_o      = (ack_o && !r_we) ? r_rdat : 32'h0;
  assign frame_done = ack_o & r_we & (r_idx == LAST_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_idx     <= 30'd0;
      r_we      <= 1'b0;
      r_dat     <= 32'h0;
      r_sel     <= 4'h0;
      r_inrange <= 1'b0;
      r_rdat    <= 32'h0;
      wr_count  <= 32'h0;
      rd_count  <= 32'h0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (r_state == IDLE && w_req) begin
        r_idx     <= adr_i[31:2];
        r_we      <= we_i;
        r_dat     <= dat_i;
        r_sel     <= sel_i;
        r_inrange <= w_adr_inrange;
      end
      if (w_next == RESP) r_rdat <= w_rd_ok ? r_mem[w_idx[AW-1:0]] : 32'h0;
      if (ack_o) begin
        if (r_we) wr_count <= wr_count + 32'd1;
        else      rd_count <= rd_count + 32'd1;
      end
    end
  end

  // Storage is never cleared; only the acked write lanes change.
  always_ff @(posedge clk) begin
    if (!rst && ack_o && r_we) begin
      for (int b = 0; b < 4; b++)
        if (r_sel[b]) r_mem[r_idx[AW-1:0]][8*b +: 8] <= r_dat[8*b +: 8];
    end
  end
endmodule
